// File: rtl/ro_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency counter.
package ro_meas_pkg;

    localparam int unsigned CNT_W_DEF         = 16;
    localparam int unsigned GATE_W_DEF        = 16;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_GATE   = 2'd2,
        ST_DONE   = 2'd3
    } meas_state_e;

endpackage

// File: rtl/ro_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
module ro_sync #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/ro_freq_counter.sv
// Gated edge counter for a ring oscillator: warm-up, fixed-length gate window,
// saturating count with overflow flag, one-cycle done pulse.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned GATE_W        = GATE_W_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ro_in,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    // One down-counter serves both the warm-up and the gate phases.
    localparam int unsigned   TMR_W   = (GATE_W > 8) ? GATE_W : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    meas_state_e       state, state_nx;
    logic [TMR_W-1:0]  timer, timer_nx;
    logic [GATE_W-1:0] gate_len, gate_len_nx;
    logic [CNT_W-1:0]  work_cnt, work_cnt_nx, count_nx;
    logic              work_ovf, work_ovf_nx, overflow_nx;
    logic              ro_en_nx, busy_nx, done_nx;
    logic              ro_s2, ro_s3, ro_rise;

    ro_sync #(.DEPTH(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ro_in),
        .q     (ro_s2)
    );

    assign ro_rise = ro_s2 & ~ro_s3;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            gate_len <= '0;
            work_cnt <= '0;
            work_ovf <= 1'b0;
            ro_s3    <= 1'b0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            gate_len <= gate_len_nx;
            work_cnt <= work_cnt_nx;
            work_ovf <= work_ovf_nx;
            ro_s3    <= ro_s2;
            ro_en    <= ro_en_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            count    <= count_nx;
            overflow <= overflow_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        gate_len_nx = gate_len;
        work_cnt_nx = work_cnt;
        work_ovf_nx = work_ovf;
        count_nx    = count;
        overflow_nx = overflow;
        done_nx     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx    = ST_WARMUP;
                    gate_len_nx = gate_cycles;
                    timer_nx    = TMR_W'(SETTLE_CYCLES - 1);
                    work_cnt_nx = '0;
                    work_ovf_nx = 1'b0;
                end
            end
            ST_WARMUP: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (timer == '0) begin
                    if (gate_len == '0) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_GATE;
                        timer_nx = TMR_W'(gate_len) - TMR_W'(1);
                    end
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            ST_GATE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else begin
                    if (ro_rise) begin
                        if (work_cnt == CNT_MAX) begin
                            work_ovf_nx = 1'b1;
                        end else begin
                            work_cnt_nx = work_cnt + CNT_W'(1);
                        end
                    end
                    if (timer == '0) begin
                        state_nx = ST_DONE;
                    end else begin
                        timer_nx = timer - TMR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                // Result registers load as DONE is left, so done and count appear together.
                state_nx    = ST_IDLE;
                done_nx     = 1'b1;
                count_nx    = work_cnt;
                overflow_nx = work_ovf;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        ro_en_nx = (state_nx == ST_WARMUP) || (state_nx == ST_GATE);
        busy_nx  = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: table of measurements plus abort, reset and busy sequences.
module tb_ro_freq_counter;

    localparam int unsigned S    = 4;
    localparam int unsigned GW   = 16;
    localparam int unsigned NMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [GW-1:0] gate_cycles = '0;
    logic          ro_in = 1'b0;

    logic          ro_en, busy, done, overflow;
    logic [15:0]   count;
    logic          ro_en_n, busy_n, done_n, overflow_n;
    logic [3:0]    count_n;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned ro_period = 0;
    int unsigned ro_phase  = 0;

    ro_freq_counter u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .ro_in(ro_in), .ro_en(ro_en),
        .busy(busy), .done(done), .count(count), .overflow(overflow)
    );

    ro_freq_counter #(.CNT_W(4)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .ro_in(ro_in), .ro_en(ro_en_n),
        .busy(busy_n), .done(done_n), .count(count_n), .overflow(overflow_n)
    );

    always #5 clk = ~clk;

    // Square-wave oscillator model, updated away from the sampling edge.
    always @(negedge clk) begin
        if (ro_period == 0) begin
            ro_in    = 1'b0;
            ro_phase = 0;
        end else begin
            ro_in    = (ro_phase < ro_period / 2);
            ro_phase = (ro_phase + 1 >= ro_period) ? 0 : ro_phase + 1;
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one measurement and follow it to the done pulse (bounded).
    task automatic run_meas(input int unsigned g, input bit abort_in_done,
                            input int unsigned restart_at,
                            output int unsigned lat, output int unsigned en_cyc,
                            output bit timed_out, output bit done_n_ok);
        int unsigned n;
        @(posedge clk); #1;
        start = 1'b1;
        gate_cycles = GW'(g);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; en_cyc = 0; lat = 0; timed_out = 1'b1; done_n_ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done) begin
                lat = n;
                timed_out = 1'b0;
                done_n_ok = done_n;
                break;
            end
            if (ro_en) en_cyc++;
            if (abort_in_done && n == S + g) abort = 1'b1;
            if (restart_at != 0 && n == restart_at) start = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            n++;
        end
    endtask

    typedef struct {
        int unsigned period;
        int unsigned gate;
        bit          abort_done;
        bit          wide_ok;
        int unsigned exp_count;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned lat, en_cyc, n_done, exp_n;
        bit          to, dn_ok;

        vecs[0] = '{period: 4,  gate: 100, abort_done: 0, wide_ok: 1, exp_count: 25};
        vecs[1] = '{period: 4,  gate: 0,   abort_done: 0, wide_ok: 1, exp_count: 0};
        vecs[2] = '{period: 8,  gate: 64,  abort_done: 0, wide_ok: 1, exp_count: 8};
        vecs[3] = '{period: 0,  gate: 20,  abort_done: 0, wide_ok: 1, exp_count: 0};
        vecs[4] = '{period: 6,  gate: 30,  abort_done: 0, wide_ok: 1, exp_count: 5};
        vecs[5] = '{period: 2,  gate: 40,  abort_done: 0, wide_ok: 0, exp_count: 20};
        vecs[6] = '{period: 4,  gate: 8,   abort_done: 1, wide_ok: 1, exp_count: 2};
        vecs[7] = '{period: 10, gate: 50,  abort_done: 0, wide_ok: 1, exp_count: 5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ro_en", 32'(ro_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ro_period = vecs[i].period;
            repeat (12) @(posedge clk);
            run_meas(vecs[i].gate, vecs[i].abort_done, 0, lat, en_cyc, to, dn_ok);
            check($sformatf("v%0d_timeout", i), 32'(to), 0);
            check($sformatf("v%0d_latency", i), lat, S + vecs[i].gate + 1);
            check($sformatf("v%0d_ro_en_cycles", i), en_cyc, S + vecs[i].gate);
            if (vecs[i].wide_ok) begin
                check($sformatf("v%0d_count", i), 32'(count), vecs[i].exp_count);
                check($sformatf("v%0d_overflow", i), 32'(overflow), 0);
            end
            exp_n = (vecs[i].exp_count > NMAX) ? NMAX : vecs[i].exp_count;
            check($sformatf("v%0d_done_narrow", i), 32'(dn_ok), 1);
            check($sformatf("v%0d_count_narrow", i), 32'(count_n), exp_n);
            check($sformatf("v%0d_ovf_narrow", i), 32'(overflow_n), 32'(vecs[i].exp_count > NMAX));
            @(posedge clk); #1;
            check($sformatf("v%0d_done_single", i), 32'(done), 0);
            check($sformatf("v%0d_count_hold", i), 32'(count_n), exp_n);
        end

        // Abort in the 10th gate cycle after a completed count of 25
        ro_period = 4;
        repeat (12) @(posedge clk);
        run_meas(100, 1'b0, 0, lat, en_cyc, to, dn_ok);
        check("ab_pre_count", 32'(count), 25);
        @(posedge clk); #1;
        start = 1'b1; gate_cycles = GW'(100);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (S + 9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_ro_en", 32'(ro_en), 0);
        check("ab_busy", 32'(busy), 0);
        n_done = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        check("ab_no_done", n_done, 0);
        check("ab_count_kept", 32'(count), 25);

        // Reset asserted mid-gate discards the measurement
        @(posedge clk); #1;
        start = 1'b1; gate_cycles = GW'(100);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (S + 5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ro_en", 32'(ro_en), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        check("post_rst_idle", n_done, 0);

        // Start pulses while busy are ignored: exactly one done
        n_done = 0;
        run_meas(20, 1'b0, 3, lat, en_cyc, to, dn_ok);
        check("busy_start_latency", lat, S + 20 + 1);
        check("busy_start_count", 32'(count), 5);
        n_done = 32'(!to);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (done) n_done++;
        end
        check("busy_start_one_done", n_done, 1);
        check("busy_start_idle", 32'(busy), 0);

        // start with abort in IDLE stays IDLE
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", 32'(busy), 0);
        check("start_abort_idle_ro_en", 32'(ro_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
